sram_arbiter: RTL and testbench

//  Shares one single-port sram instance between two requesters (M0, M1), one access per cycle.

---
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of one single-port SRAM, with optional locked bursts.
// Latency: grant and SRAM drive are combinational; read data returns one cycle after the read beat.
// Backpressure: a master is stalled by holding its GNT low; it keeps REQ/ADDR/WE/WDATA stable until GNT.
module sram_arbiter #(
   parameter int DATAWIDTH  = 32,
   parameter int ADDERWIDTH = 16,
   parameter int MAX_BURST  = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      M0_REQ,
   input  logic                      M0_LOCK,
   input  logic [ADDERWIDTH-1:0]     M0_ADDR,
   input  logic [DATAWIDTH/8-1:0]    M0_WE,
   input  logic [DATAWIDTH-1:0]      M0_WDATA,
   output logic                      M0_GNT,
   output logic                      M0_RVALID,
   output logic [DATAWIDTH-1:0]      M0_RDATA,
   input  logic                      M1_REQ,
   input  logic                      M1_LOCK,
   input  logic [ADDERWIDTH-1:0]     M1_ADDR,
   input  logic [DATAWIDTH/8-1:0]    M1_WE,
   input  logic [DATAWIDTH-1:0]      M1_WDATA,
   output logic                      M1_GNT,
   output logic                      M1_RVALID,
   output logic [DATAWIDTH-1:0]      M1_RDATA,
   output logic                      S_CS,
   output logic [ADDERWIDTH-1:0]     S_ADDRESS,
   output logic [DATAWIDTH/8-1:0]    S_WE,
   output logic [DATAWIDTH-1:0]      S_WDATA,
   input  logic [DATAWIDTH-1:0]      S_RDATA
);

   localparam int BEW = DATAWIDTH / 8;
   // Stored burst count never exceeds MAX_BURST-1, so this width is enough.
   localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   // A locked beat may extend the burst only while count+1 < MAX_BURST, i.e. count < MAX_BURST-1.
   localparam logic [BW-1:0] BCNT_LIM = BW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   last_q, last_d;
   logic [BW-1:0]          bcnt_q, bcnt_d;
   logic                   m0_rvalid_q, m0_rvalid_d;
   logic                   m1_rvalid_q, m1_rvalid_d;
   logic [DATAWIDTH-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DATAWIDTH-1:0]   m1_rdata_q, m1_rdata_d;

   logic                   gnt0, gnt1;
   logic                   rd0, rd1;
   logic [BW-1:0]          base_cnt;

   // Grant selection: locked owner first, then single requester, then the master not served last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!RST) begin
         if (state_q == ST_OWN0 && M0_REQ) begin
            gnt0 = 1'b1;
         end else if (state_q == ST_OWN1 && M1_REQ) begin
            gnt1 = 1'b1;
         end else if (M0_REQ && M1_REQ) begin
            // last_q==1 means M1 was served last, so M0 wins the tie.
            if (last_q) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else if (M0_REQ) begin
            gnt0 = 1'b1;
         end else if (M1_REQ) begin
            gnt1 = 1'b1;
         end
      end
   end

   // Ownership, last-served pointer and burst count update on each beat.
   always_comb begin
      state_d  = ST_IDLE;
      last_d   = last_q;
      bcnt_d   = '0;
      base_cnt = '0;
      if (gnt0) begin
         last_d = 1'b0;
         // A burst only continues counting if this master already owned the bus.
         base_cnt = (state_q == ST_OWN0) ? bcnt_q : '0;
         if (M0_LOCK && (base_cnt < BCNT_LIM)) begin
            state_d = ST_OWN0;
            bcnt_d  = base_cnt + BW'(1);
         end
      end else if (gnt1) begin
         last_d = 1'b1;
         base_cnt = (state_q == ST_OWN1) ? bcnt_q : '0;
         if (M1_LOCK && (base_cnt < BCNT_LIM)) begin
            state_d = ST_OWN1;
            bcnt_d  = base_cnt + BW'(1);
         end
      end
      // No beat: either idle already or the owner dropped REQ; both release the bus.
   end

   // SRAM drive from the granted master; all zero when nothing is granted.
   always_comb begin
      S_CS      = 1'b0;
      S_ADDRESS = '0;
      S_WE      = '0;
      S_WDATA   = '0;
      if (gnt0) begin
         S_CS      = 1'b1;
         S_ADDRESS = M0_ADDR;
         S_WE      = M0_WE;
         S_WDATA   = M0_WDATA;
      end else if (gnt1) begin
         S_CS      = 1'b1;
         S_ADDRESS = M1_ADDR;
         S_WE      = M1_WE;
         S_WDATA   = M1_WDATA;
      end
   end

   // Read return path: capture SRAM data at the end of a read beat, hold it until the next read.
   always_comb begin
      rd0         = gnt0 && (M0_WE == {BEW{1'b0}});
      rd1         = gnt1 && (M1_WE == {BEW{1'b0}});
      m0_rvalid_d = rd0;
      m1_rvalid_d = rd1;
      m0_rdata_d  = rd0 ? S_RDATA : m0_rdata_q;
      m1_rdata_d  = rd1 ? S_RDATA : m1_rdata_q;
   end

   // State and return-path registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         bcnt_q      <= '0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         bcnt_q      <= bcnt_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   assign M0_GNT    = gnt0;
   assign M1_GNT    = gnt1;
   assign M0_RVALID = m0_rvalid_q;
   assign M1_RVALID = m1_rvalid_q;
   assign M0_RDATA  = m0_rdata_q;
   assign M1_RDATA  = m1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM plus a cycle-by-cycle vector table.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
// A second instance with MAX_BURST=1 checks that LOCK is ignored there.
module tb_sram_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 16;
   localparam int BEW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          m0_req, m0_lock, m1_req, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [BEW-1:0] m0_we, m1_we;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          s_cs;
   logic [AW-1:0] s_address;
   logic [BEW-1:0] s_we;
   logic [DW-1:0] s_wdata, s_rdata;

   sram_arbiter #(.DATAWIDTH(DW), .ADDERWIDTH(AW), .MAX_BURST(4)) u_dut (
      .CLK(clk), .RST(rst),
      .M0_REQ(m0_req), .M0_LOCK(m0_lock), .M0_ADDR(m0_addr), .M0_WE(m0_we), .M0_WDATA(m0_wdata),
      .M0_GNT(m0_gnt), .M0_RVALID(m0_rvalid), .M0_RDATA(m0_rdata),
      .M1_REQ(m1_req), .M1_LOCK(m1_lock), .M1_ADDR(m1_addr), .M1_WE(m1_we), .M1_WDATA(m1_wdata),
      .M1_GNT(m1_gnt), .M1_RVALID(m1_rvalid), .M1_RDATA(m1_rdata),
      .S_CS(s_cs), .S_ADDRESS(s_address), .S_WE(s_we), .S_WDATA(s_wdata), .S_RDATA(s_rdata)
   );

   // Second instance: pure round-robin, no SRAM behind it.
   logic          b_m0_req, b_m0_lock, b_m1_req, b_m1_lock;
   logic [AW-1:0] b_m0_addr, b_m1_addr;
   logic [BEW-1:0] b_m0_we, b_m1_we;
   logic [DW-1:0] b_m0_wdata, b_m1_wdata;
   logic          b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
   logic [DW-1:0] b_m0_rdata, b_m1_rdata;
   logic          b_s_cs;
   logic [AW-1:0] b_s_address;
   logic [BEW-1:0] b_s_we;
   logic [DW-1:0] b_s_wdata;
   logic [DW-1:0] b_s_rdata = '0;

   sram_arbiter #(.DATAWIDTH(DW), .ADDERWIDTH(AW), .MAX_BURST(1)) u_rr (
      .CLK(clk), .RST(rst),
      .M0_REQ(b_m0_req), .M0_LOCK(b_m0_lock), .M0_ADDR(b_m0_addr), .M0_WE(b_m0_we), .M0_WDATA(b_m0_wdata),
      .M0_GNT(b_m0_gnt), .M0_RVALID(b_m0_rvalid), .M0_RDATA(b_m0_rdata),
      .M1_REQ(b_m1_req), .M1_LOCK(b_m1_lock), .M1_ADDR(b_m1_addr), .M1_WE(b_m1_we), .M1_WDATA(b_m1_wdata),
      .M1_GNT(b_m1_gnt), .M1_RVALID(b_m1_rvalid), .M1_RDATA(b_m1_rdata),
      .S_CS(b_s_cs), .S_ADDRESS(b_s_address), .S_WE(b_s_we), .S_WDATA(b_s_wdata), .S_RDATA(b_s_rdata)
   );

   // Behavioural SRAM: unwritten words read as A5000000|addr, byte-merged writes at the clock edge.
   logic [DW-1:0] mem [0:255];
   logic [255:0]  written = '0;

   always @(posedge clk) begin
      if (s_cs && (s_we != '0)) begin
         for (int b = 0; b < BEW; b++) begin
            if (s_we[b]) begin
               mem[s_address[7:0]][b*8 +: 8] <= s_wdata[b*8 +: 8];
            end else if (!written[s_address[7:0]]) begin
               mem[s_address[7:0]][b*8 +: 8] <= 8'(32'hA500_0000 >> (b*8)) | ((b == 0) ? s_address[7:0] : 8'h00);
            end
         end
         written[s_address[7:0]] <= 1'b1;
      end
   end

   assign s_rdata = (s_cs && (s_we == '0))
                    ? (written[s_address[7:0]] ? mem[s_address[7:0]] : (32'hA500_0000 | {24'h0, s_address[7:0]}))
                    : '0;

   typedef struct packed {
      logic          req;
      logic          lock;
      logic [15:0]   addr;
      logic [3:0]    we;
      logic [31:0]   wd;
   } mreq_t;

   typedef struct {
      logic        rst;
      mreq_t       m0;
      mreq_t       m1;
      logic        g0, g1, v0, v1;
      logic [31:0] rd0, rd1;
   } vec_t;

   function automatic mreq_t NO();
      return '{req: 1'b0, lock: 1'b0, addr: 16'h0, we: 4'h0, wd: 32'h0};
   endfunction
   function automatic mreq_t RD(input logic [15:0] a);
      return '{req: 1'b1, lock: 1'b0, addr: a, we: 4'h0, wd: 32'h0};
   endfunction
   function automatic mreq_t LRD(input logic [15:0] a);
      return '{req: 1'b1, lock: 1'b1, addr: a, we: 4'h0, wd: 32'h0};
   endfunction
   function automatic mreq_t WR(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
      return '{req: 1'b1, lock: 1'b0, addr: a, we: w, wd: d};
   endfunction
   function automatic vec_t V(input logic r, input mreq_t a, input mreq_t b,
                              input logic g0, input logic g1, input logic v0, input logic v1,
                              input logic [31:0] rd0, input logic [31:0] rd1);
      vec_t t;
      t.rst = r; t.m0 = a; t.m1 = b;
      t.g0 = g0; t.g1 = g1; t.v0 = v0; t.v1 = v1; t.rd0 = rd0; t.rd1 = rd1;
      return t;
   endfunction

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst      = t.rst;
      m0_req   = t.m0.req;  m0_lock = t.m0.lock; m0_addr = t.m0.addr; m0_we = t.m0.we; m0_wdata = t.m0.wd;
      m1_req   = t.m1.req;  m1_lock = t.m1.lock; m1_addr = t.m1.addr; m1_we = t.m1.we; m1_wdata = t.m1.wd;
   endtask

   vec_t tv[$];

   initial begin
      logic [15:0] ex_addr;
      logic [3:0]  ex_we;
      logic [31:0] ex_wd;
      logic [31:0] A30, DB, BY;
      A30 = 32'hA500_0030;
      DB  = 32'hDEAD_BEEF;
      BY  = 32'h1122_AB44;

      // reset, first grant, write then read
      tv.push_back(V(1, RD(16'h10), RD(16'h30), 0, 0, 0, 0, 0, 0));
      tv.push_back(V(0, WR(16'h10, 4'hF, DB), RD(16'h30), 1, 0, 0, 0, 0, 0));
      tv.push_back(V(0, RD(16'h10), RD(16'h30), 0, 1, 0, 0, 0, 0));
      tv.push_back(V(0, RD(16'h10), NO(),       1, 0, 0, 1, 0, A30));
      tv.push_back(V(0, NO(), NO(),             0, 0, 1, 0, DB, A30));
      // round-robin with continuous reads
      tv.push_back(V(0, RD(16'h10), RD(16'h30), 0, 1, 0, 0, DB, A30));
      tv.push_back(V(0, RD(16'h10), RD(16'h30), 1, 0, 0, 1, DB, A30));
      tv.push_back(V(0, RD(16'h10), RD(16'h30), 0, 1, 1, 0, DB, A30));
      tv.push_back(V(0, RD(16'h10), RD(16'h30), 1, 0, 0, 1, DB, A30));
      tv.push_back(V(0, NO(), NO(),             0, 0, 1, 0, DB, A30));
      // byte write and read-after-write
      tv.push_back(V(0, NO(), WR(16'h20, 4'hF, 32'h1122_3344), 0, 1, 0, 0, DB, A30));
      tv.push_back(V(0, NO(), WR(16'h20, 4'h2, 32'h0000_AB00), 0, 1, 0, 0, DB, A30));
      tv.push_back(V(0, NO(), RD(16'h20),       0, 1, 0, 0, DB, A30));
      tv.push_back(V(0, NO(), NO(),             0, 0, 0, 1, DB, BY));
      // locked burst capped at 4, then M1, then M0 again; owner drop hands over at once
      tv.push_back(V(0, LRD(16'h10), RD(16'h30), 1, 0, 0, 0, DB, BY));
      tv.push_back(V(0, LRD(16'h10), RD(16'h30), 1, 0, 1, 0, DB, BY));
      tv.push_back(V(0, LRD(16'h10), RD(16'h30), 1, 0, 1, 0, DB, BY));
      tv.push_back(V(0, LRD(16'h10), RD(16'h30), 1, 0, 1, 0, DB, BY));
      tv.push_back(V(0, LRD(16'h10), RD(16'h30), 0, 1, 1, 0, DB, BY));
      tv.push_back(V(0, LRD(16'h10), RD(16'h30), 1, 0, 0, 1, DB, A30));
      tv.push_back(V(0, LRD(16'h10), RD(16'h30), 1, 0, 1, 0, DB, A30));
      tv.push_back(V(0, NO(), RD(16'h30),       0, 1, 1, 0, DB, A30));
      tv.push_back(V(0, NO(), NO(),             0, 0, 0, 1, DB, A30));
      // reset during beat 2 of an M1 locked read burst
      tv.push_back(V(0, NO(), LRD(16'h20),      0, 1, 0, 0, DB, A30));
      tv.push_back(V(1, RD(16'h10), LRD(16'h20), 0, 0, 0, 1, DB, BY));
      tv.push_back(V(0, RD(16'h10), LRD(16'h20), 1, 0, 0, 0, 0, 0));
      tv.push_back(V(0, NO(), LRD(16'h20),      0, 1, 1, 0, DB, 0));
      tv.push_back(V(0, NO(), NO(),             0, 0, 0, 1, DB, BY));

      b_m0_req = 0; b_m0_lock = 0; b_m0_addr = '0; b_m0_we = '0; b_m0_wdata = '0;
      b_m1_req = 0; b_m1_lock = 0; b_m1_addr = '0; b_m1_we = '0; b_m1_wdata = '0;

      // Reset preamble: one edge with RST high; the first table row keeps it high a second cycle.
      drive(tv[0]);
      @(posedge clk); #1;

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i]);
         #3;
         ex_addr = tv[i].g0 ? tv[i].m0.addr : (tv[i].g1 ? tv[i].m1.addr : 16'h0);
         ex_we   = tv[i].g0 ? tv[i].m0.we   : (tv[i].g1 ? tv[i].m1.we   : 4'h0);
         ex_wd   = tv[i].g0 ? tv[i].m0.wd   : (tv[i].g1 ? tv[i].m1.wd   : 32'h0);
         check("m0_gnt",    i, m0_gnt,    tv[i].g0);
         check("m1_gnt",    i, m1_gnt,    tv[i].g1);
         check("s_cs",      i, s_cs,      tv[i].g0 | tv[i].g1);
         check("s_address", i, s_address, ex_addr);
         check("s_we",      i, s_we,      ex_we);
         check("s_wdata",   i, s_wdata,   ex_wd);
         check("m0_rvalid", i, m0_rvalid, tv[i].v0);
         check("m1_rvalid", i, m1_rvalid, tv[i].v1);
         check("m0_rdata",  i, m0_rdata,  tv[i].rd0);
         check("m1_rdata",  i, m1_rdata,  tv[i].rd1);
         @(posedge clk); #1;
      end

      // MAX_BURST=1: both masters hold LOCK, grants must still alternate M0,M1,M0,M1.
      b_m0_req = 1; b_m0_lock = 1; b_m0_addr = 16'h4;
      b_m1_req = 1; b_m1_lock = 1; b_m1_addr = 16'h8;
      for (int k = 0; k < 4; k++) begin
         #3;
         check("rr_m0_gnt", k, b_m0_gnt, (k % 2) == 0);
         check("rr_m1_gnt", k, b_m1_gnt, (k % 2) == 1);
         @(posedge clk); #1;
      end
      b_m0_req = 0; b_m1_req = 0;
      #3;
      check("rr_idle_cs", 4, b_s_cs, 1'b0);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
